// File: rtl/spi_frame_rx.sv
// Purpose : receives SPI register-write frames (address byte, value byte) from an MCU into the clk domain.
// Latency : strobe is high in the cycle after the (SYNC_STAGES+1)th clk edge that samples spi_cs high.
// Backpressure: none; wr_valid / frame_err are single-cycle strobes that cannot be stalled.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   spi_clk, spi_cs,     raw SPI pins, asynchronous to clk; spi_cs and
//   spi_special,         spi_special are active low
//   spi_mosi
//   wr_addr, wr_data     address/value of the last accepted frame
//   wr_valid             one-cycle strobe for an accepted frame
//   frame_err            one-cycle strobe for a rejected frame
//   err_count            saturating count of rejected frames
//
// Build option: define SPI_FRAME_RX_ERR_COUNT_EN to enable the err_count
// counter; otherwise err_count is tied to zero.
module spi_frame_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_clk,
  input  logic       spi_cs,
  input  logic       spi_special,
  input  logic       spi_mosi,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  // Synchronizer chains; bit SYNC_STAGES-1 is the synchronized copy.
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] spc_sync_q, spc_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  // Fills with ones after reset; once full, the cs chain holds real samples
  // rather than its reset value.
  logic [SYNC_STAGES-1:0] flush_q, flush_d;

  logic [SYNC_STAGES:0] sclk_ext, cs_ext, spc_ext, mosi_ext, flush_ext;

  logic sclk_s, cs_s, spc_s, mosi_s, sclk_fall, sync_live;

  logic                  sclk_prev_q, sclk_prev_d;
  logic                  armed_q, armed_d;
  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  frame_err_q, frame_err_d;

  assign sclk_ext  = {sclk_sync_q, spi_clk};
  assign cs_ext    = {cs_sync_q, spi_cs};
  assign spc_ext   = {spc_sync_q, spi_special};
  assign mosi_ext  = {mosi_sync_q, spi_mosi};
  assign flush_ext = {flush_q, 1'b1};

  always_comb begin
    sclk_sync_d = sclk_ext[SYNC_STAGES-1:0];
    cs_sync_d   = cs_ext[SYNC_STAGES-1:0];
    spc_sync_d  = spc_ext[SYNC_STAGES-1:0];
    mosi_sync_d = mosi_ext[SYNC_STAGES-1:0];
    flush_d     = flush_ext[SYNC_STAGES-1:0];
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign spc_s     = spc_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sync_live = flush_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  always_comb begin
    sclk_prev_d = sclk_s;
    // A frame may only start after cs has genuinely been seen high, so a
    // reset released mid-frame does not pick up the frame tail.
    armed_d     = armed_q | (sync_live & cs_s);
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !cs_s && !spc_s) begin
          state_d = ST_RECV;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_RECV: begin
        // Shift first so a final edge coinciding with cs rise is counted.
        if (sclk_fall) begin
          shift_d = {shift_q[FRAME_BITS-2:0], mosi_s};
          cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
        if (cs_s) begin
          state_d = ST_IDLE;
          if (cnt_d == CNT_FULL) begin
            wr_addr_d  = shift_d[FRAME_BITS-1 -: 8];
            wr_data_d  = shift_d[7:0];
            wr_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (spc_s) begin
          state_d     = ST_ABORT;
          frame_err_d = 1'b1;
        end
      end
      ST_ABORT: begin
        if (cs_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      spc_sync_q  <= '1;
      mosi_sync_q <= '0;
      flush_q     <= '0;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      spc_sync_q  <= spc_sync_d;
      mosi_sync_q <= mosi_sync_d;
      flush_q     <= flush_d;
      sclk_prev_q <= sclk_prev_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_valid  = wr_valid_q;
  assign frame_err = frame_err_q;

`ifdef SPI_FRAME_RX_ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts alongside the strobe so err_count is current while frame_err is high.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
module tb_spi_frame_rx;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;   // spi_clk = clk/8

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_special = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [7:0] wr_addr, wr_data, err_count;
  logic       wr_valid, frame_err;

  spi_frame_rx #(.FRAME_BITS(16), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_special(spi_special), .spi_mosi(spi_mosi),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  errc;
    int unsigned exp_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t push_e;

  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;
  logic [7:0] exp_err   = 8'h00;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Called at a negedge in the same step the frame-ending input changes.
  function automatic void push_wr(input logic [15:0] v);
    push_e.is_wr   = 1'b1;
    push_e.addr    = v[15:8];
    push_e.data    = v[7:0];
    push_e.errc    = exp_err;
    push_e.exp_cyc = cyc + SYNC_STAGES + 1;
    exp_q.push_back(push_e);
    last_addr = v[15:8];
    last_data = v[7:0];
  endfunction

  function automatic void push_err();
`ifdef SPI_FRAME_RX_ERR_COUNT_EN
    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
`endif
    push_e.is_wr   = 1'b0;
    push_e.addr    = last_addr;
    push_e.data    = last_data;
    push_e.errc    = exp_err;
    push_e.exp_cyc = cyc + SYNC_STAGES + 1;
    exp_q.push_back(push_e);
  endfunction

  // Monitor: pops an expectation on every strobe, flags strobes that never came.
  always @(negedge clk) begin
    if (wr_valid || frame_err) begin
      chk("strobe_exclusive", 32'(wr_valid & frame_err), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'({wr_valid, frame_err}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_kind_wr_valid", 32'(wr_valid), 32'(mon_e.is_wr));
        chk("strobe_cycle", 32'(cyc), 32'(mon_e.exp_cyc));
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(wr_data), 32'(mon_e.data));
        chk("err_count_at_strobe", 32'(err_count), 32'(mon_e.errc));
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].exp_cyc) begin
      chk("missing_strobe_cycle", 32'(cyc), 32'(exp_q[0].exp_cyc));
      void'(exp_q.pop_front());
    end
  end

  task automatic start_frame(input logic sp);
    @(negedge clk);
    spi_special = sp;
    repeat (4) @(negedge clk);
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = v[i];
      spi_clk  = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk  = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask

  // kind: 0 = no strobe expected, 1 = write of v, 2 = rejected frame
  task automatic end_frame(input int kind, input logic [15:0] v);
    @(negedge clk);
    if (kind == 1) push_wr(v);
    else if (kind == 2) push_err();
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_wr_valid", 32'(wr_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_wr_data", 32'(wr_data), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Good 16-bit frame
    start_frame(1'b0);
    send_bits(32'h0703, 16);
    end_frame(1, 16'h0703);

    // Short and long frames
    start_frame(1'b0);
    send_bits(32'h1234, 15);
    end_frame(2, 16'h0000);
    start_frame(1'b0);
    send_bits(32'h1ABCD, 17);
    end_frame(2, 16'h0000);
    chk("err_count_after_len_errors", 32'(err_count), 32'(exp_err));
    chk("wr_addr_kept", 32'(wr_addr), 32'h07);
    chk("wr_data_kept", 32'(wr_data), 32'h03);

    // Special rises after 9 bits of 0x08A5
    start_frame(1'b0);
    send_bits(32'h08A5 >> 7, 9);
    @(negedge clk);
    push_err();
    spi_special = 1'b1;
    repeat (6) @(negedge clk);
    send_bits(32'h08A5 & 32'h7F, 7);
    end_frame(0, 16'h0000);
    start_frame(1'b0);
    send_bits(32'h0901, 16);
    end_frame(1, 16'h0901);

    // Pass-through traffic
    start_frame(1'b1);
    send_bits(32'h0BCD, 16);
    end_frame(0, 16'h0000);
    chk("err_count_after_special_frame", 32'(err_count), 32'(exp_err));
    chk("wr_addr_after_special_frame", 32'(wr_addr), 32'h09);

    // Reset mid-frame with cs held low
    start_frame(1'b0);
    send_bits(32'h07, 8);
    @(negedge clk);
    rst_n = 1'b0;
    last_addr = 8'h00;
    last_data = 8'h00;
    exp_err   = 8'h00;
    repeat (3) @(negedge clk);
    chk("midreset_wr_addr", 32'(wr_addr), 32'd0);
    chk("midreset_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(32'h02, 8);
    end_frame(0, 16'h0000);
    start_frame(1'b0);
    send_bits(32'h0702, 16);
    end_frame(1, 16'h0702);

    // Many empty frames drive err_count to saturation
    for (int k = 0; k < 300; k++) begin
      start_frame(1'b0);
      end_frame(2, 16'h0000);
    end
`ifdef SPI_FRAME_RX_ERR_COUNT_EN
    chk("err_count_saturated", 32'(err_count), 32'd255);
`else
    chk("err_count_tied_zero", 32'(err_count), 32'd0);
`endif
    chk("wr_data_after_errors", 32'(wr_data), 32'h02);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
